wide_uart_initiator: RTL and testbench



---
 rtl/wide_uart_initiator.sv | 201 ++++++++++++++++++++
 tb/tb_wide_uart_initiator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wide_uart_initiator.sv
// Host-side UART initiator: sends a control byte plus WIDTH data bytes, then
// collects a status byte plus WIDTH data bytes from the responder.
module wide_uart_initiator #(
    parameter int unsigned BIT_CLOCKS   = 104,
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic                 masterClock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           control,
    input  logic [8*WIDTH-1:0]   outputData,
    input  logic                 rx,
    output logic                 tx,
    output logic                 busy,
    output logic [7:0]           status,
    output logic [8*WIDTH-1:0]   inputData,
    output logic                 done,
    output logic                 timeout,
    output logic                 frameError
);

    localparam int unsigned NBYTES     = WIDTH + 1;
    localparam int unsigned RW         = 8 * NBYTES;
    localparam int unsigned FRAME_BITS = 10 * NBYTES;
    localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * BIT_CLOCKS;
    localparam int unsigned CW         = $clog2(BIT_CLOCKS);
    localparam int unsigned FW         = $clog2(FRAME_BITS);
    localparam int unsigned TW         = $clog2(TMO_CYCLES + 1);
    localparam int unsigned BW         = $clog2(NBYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND   = 3'd1,
        WAIT   = 3'd2,
        RECV   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       clk_cnt;
    logic [FW-1:0]       tx_idx;
    logic [FRAME_BITS-1:0] tx_frame;
    logic [TW-1:0]       tmo_cnt;
    logic                rx_s1;
    logic                rx_s2;
    logic                rx_prev;
    logic [3:0]          rx_bit;
    logic [7:0]          rx_byte;
    logic [BW-1:0]       rx_count;
    logic [RW-1:0]       rx_shift;

    logic [RW-1:0]         cmd_c;
    logic [FRAME_BITS-1:0] frame_c;
    logic                  bit_end_c;
    logic                  tx_last_c;
    logic                  fall_c;
    logic [CW-1:0]         rx_target_c;
    logic                  sample_c;
    logic                  rx_last_c;
    logic                  tmo_exp_c;

    // Full 8N1 command frame, transmitted from bit 0 upward
    assign cmd_c = {control, outputData};
    for (genvar b = 0; b < NBYTES; b++) begin : g_frame
        assign frame_c[10*b +: 10] = {1'b1, cmd_c[RW-8-8*b +: 8], 1'b0};
    end

    // State register
    always_ff @(posedge masterClock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = SEND;
            SEND:   if (bit_end_c && tx_last_c) state_nxt = WAIT;
            WAIT: begin
                if (tmo_exp_c)   state_nxt = IDLE;
                else if (fall_c) state_nxt = RECV;
            end
            RECV: begin
                if (sample_c) begin
                    if (rx_bit == 4'd0 && rx_s2) state_nxt = WAIT;
                    else if (rx_bit == 4'd9)     state_nxt = rx_last_c ? FINISH : WAIT;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Timing strobes; the start bit is sampled half a bit in, the rest a full bit apart
    always_comb begin
        bit_end_c   = (clk_cnt == CW'(BIT_CLOCKS - 1));
        tx_last_c   = (tx_idx == FW'(FRAME_BITS - 1));
        fall_c      = rx_prev & ~rx_s2;
        rx_target_c = (rx_bit == 4'd0) ? CW'(BIT_CLOCKS / 2 - 1) : CW'(BIT_CLOCKS - 1);
        sample_c    = (clk_cnt == rx_target_c);
        rx_last_c   = (rx_count == BW'(WIDTH));
        tmo_exp_c   = (tmo_cnt == TW'(1));
    end

    // Datapath and registered outputs
    always_ff @(posedge masterClock) begin
        if (reset) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            status     <= '0;
            inputData  <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            frameError <= 1'b0;
            clk_cnt    <= '0;
            tx_idx     <= '0;
            tx_frame   <= '1;
            tmo_cnt    <= '0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_count   <= '0;
            rx_shift   <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_frame   <= frame_c;
                        tx         <= frame_c[0];
                        tx_idx     <= '0;
                        clk_cnt    <= '0;
                        busy       <= 1'b1;
                        frameError <= 1'b0;
                        rx_count   <= '0;
                    end
                end
                SEND: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        if (tx_last_c) begin
                            tx      <= 1'b1;
                            tmo_cnt <= TW'(TMO_CYCLES);
                        end else begin
                            tx_frame <= tx_frame >> 1;
                            tx       <= tx_frame[1];
                            tx_idx   <= tx_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (tmo_exp_c) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (fall_c) begin
                        tmo_cnt <= TW'(TMO_CYCLES);
                        clk_cnt <= '0;
                        rx_bit  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                RECV: begin
                    if (sample_c) begin
                        clk_cnt <= '0;
                        rx_bit  <= rx_bit + 4'd1;
                        if (rx_bit == 4'd9) begin
                            rx_shift <= {rx_shift[RW-9:0], rx_byte};
                            rx_count <= rx_count + 1'b1;
                            if (!rx_s2) frameError <= 1'b1;
                        end else if (rx_bit != 4'd0) begin
                            rx_byte <= {rx_s2, rx_byte[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    status    <= rx_shift[RW-1 -: 8];
                    inputData <= rx_shift[RW-9:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_uart_initiator.sv
// Self-checking bench for wide_uart_initiator: transmit framing, round trips,
// timeout, glitch rejection, framing error, busy-start and reset.
module tb_wide_uart_initiator;

    localparam int unsigned BC = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned TB = 16;

    logic        masterClock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  control;
    logic [31:0] outputData;
    logic        rx;
    logic        tx;
    logic        busy;
    logic [7:0]  status;
    logic [31:0] inputData;
    logic        done;
    logic        timeout;
    logic        frameError;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int tmo_pulses = 0;
    logic [7:0]  snap_status;
    logic [31:0] snap_data;

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] odata;
        logic [7:0]  rstat;
        logic [31:0] rdata;
        logic        bad_stop;
        logic        exp_fe;
    } vec_t;
    vec_t vecs[3];

    always #5 masterClock = ~masterClock;

    wide_uart_initiator #(.BIT_CLOCKS(BC), .WIDTH(W), .TIMEOUT_BITS(TB)) dut (
        .masterClock(masterClock),
        .reset(reset),
        .start(start),
        .control(control),
        .outputData(outputData),
        .rx(rx),
        .tx(tx),
        .busy(busy),
        .status(status),
        .inputData(inputData),
        .done(done),
        .timeout(timeout),
        .frameError(frameError)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock, sampled just after the edge; records done/timeout pulses
    task automatic tick();
        @(posedge masterClock);
        #1;
        if (done) begin
            done_cnt++;
            snap_status = status;
            snap_data   = inputData;
        end
        if (timeout) tmo_pulses++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (BC) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BC) tick();
        end
        rx = stop_v;
        repeat (BC) tick();
        rx = 1'b1;
    endtask

    task automatic respond(input logic [7:0] s, input logic [31:0] d, input logic bad);
        logic [39:0] f;
        f = {s, d};
        repeat (BC) tick();
        for (int j = 0; j < 5; j++) begin
            send_byte(f[39-8*j -: 8], (j == 4) ? ~bad : 1'b1);
            repeat (3 * BC) tick();
        end
    endtask

    // Issue a start and check every tx cycle of the 400-cycle command frame
    task automatic run_tx(input logic [7:0] c, input logic [31:0] d, input bit mid_start, input string nm);
        logic [39:0] cmd;
        int tx_err;
        int busy_err;
        cmd = {c, d};
        tx_err = 0;
        busy_err = 0;
        control = c;
        outputData = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            int bit_i;
            int k;
            int j;
            logic e;
            bit_i = (cyc - 1) / BC;
            k = bit_i % 10;
            j = bit_i / 10;
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = cmd[32 - 8*j + k - 1];
            if (tx !== e) tx_err++;
            if (busy !== 1'b1) busy_err++;
            if (mid_start) begin
                if (cyc == 100) begin
                    control = ~c;
                    outputData = ~d;
                    start = 1'b1;
                end else if (cyc == 101) begin
                    start = 1'b0;
                end
            end
            tick();
        end
        check({nm, " tx bit errors"}, 64'(tx_err), 64'd0);
        check({nm, " busy low cycles"}, 64'(busy_err), 64'd0);
        check({nm, " tx idle after frame"}, 64'(tx), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rx = 1'b1;
        control = '0;
        outputData = '0;
        vecs[0] = '{8'hA5, 32'h12345678, 8'h3C, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 32'hFFFFFFFF, 8'hFF, 32'h00000000, 1'b0, 1'b0};
        vecs[2] = '{8'hC3, 32'h0F1E2D3C, 8'h01, 32'h80000001, 1'b1, 1'b1};

        repeat (3) tick();
        check("reset tx", 64'(tx), 64'd1);
        check("reset busy/done/timeout/fe", 64'({busy, done, timeout, frameError}), 64'd0);
        check("reset status", 64'(status), 64'd0);
        check("reset inputData", 64'(inputData), 64'd0);
        reset = 1'b0;
        tick();

        // Round trips
        for (int i = 0; i < 3; i++) begin
            done_cnt = 0;
            tmo_pulses = 0;
            run_tx(vecs[i].ctrl, vecs[i].odata, 1'b0, $sformatf("vec%0d", i));
            respond(vecs[i].rstat, vecs[i].rdata, vecs[i].bad_stop);
            repeat (20) tick();
            check($sformatf("vec%0d done pulses", i), 64'(done_cnt), 64'd1);
            check($sformatf("vec%0d status", i), 64'(snap_status), 64'(vecs[i].rstat));
            check($sformatf("vec%0d inputData", i), 64'(snap_data), 64'(vecs[i].rdata));
            check($sformatf("vec%0d frameError", i), 64'(frameError), 64'(vecs[i].exp_fe));
            check($sformatf("vec%0d busy after", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d no timeout", i), 64'(tmo_pulses), 64'd0);
        end

        // Timeout: silent responder, pulse exactly 128 cycles after the frame ends
        done_cnt = 0;
        tmo_pulses = 0;
        run_tx(8'h11, 32'h22334455, 1'b0, "tmo");
        check("start clears frameError", 64'(frameError), 64'd0);
        repeat (127) tick();
        check("timeout not early", 64'(tmo_pulses), 64'd0);
        tick();
        check("timeout pulse", 64'(timeout), 64'd1);
        check("timeout busy low", 64'(busy), 64'd0);
        check("timeout no done", 64'(done_cnt), 64'd0);
        check("timeout keeps status", 64'(status), 64'h01);
        check("timeout keeps inputData", 64'(inputData), 64'h80000001);

        // Immediate restart, start pulsed mid-frame, then a glitch before the response
        done_cnt = 0;
        tmo_pulses = 0;
        run_tx(8'h5E, 32'hCAFEF00D, 1'b1, "busy-start");
        repeat (10) tick();
        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        repeat (20) tick();
        respond(8'h77, 32'h01234567, 1'b0);
        repeat (20) tick();
        check("glitch done pulses", 64'(done_cnt), 64'd1);
        check("glitch status", 64'(snap_status), 64'h77);
        check("glitch inputData", 64'(snap_data), 64'h01234567);
        check("glitch no timeout", 64'(tmo_pulses), 64'd0);

        // Reset during the third transmitted byte
        control = 8'h3A;
        outputData = 32'h12F03456;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (179) tick();
        check("pre-reset tx low", 64'(tx), 64'd0);
        reset = 1'b1;
        tick();
        check("reset mid-send tx", 64'(tx), 64'd1);
        check("reset mid-send busy/done/timeout/fe", 64'({busy, done, timeout, frameError}), 64'd0);
        check("reset mid-send status", 64'(status), 64'd0);
        check("reset mid-send inputData", 64'(inputData), 64'd0);
        reset = 1'b0;
        repeat (4) tick();
        check("post-reset idle", 64'({tx, busy}), 64'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
